// File: rtl/cordic_cos_iter_if.sv
// Valid/ready handshake bundle between the angle producer, the CORDIC core and the result consumer.
interface cordic_cos_iter_if #(
  parameter int unsigned WIDTH = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] theta;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] cos_out;
  logic [WIDTH-1:0] sin_out;

  modport master (
    output in_valid, theta, out_ready,
    input  in_ready, out_valid, cos_out, sin_out
  );

  modport slave (
    input  in_valid, theta, out_ready,
    output in_ready, out_valid, cos_out, sin_out
  );
endinterface

// File: rtl/cordic_cos_iter.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, Q2.22 angle in, cos/sin out.
module cordic_cos_iter #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned FRAC       = 22,
  parameter int unsigned ITERATIONS = 22
) (
  input  logic               clk,
  input  logic               reset,
  cordic_cos_iter_if.slave   bus
);
  localparam int unsigned XW = WIDTH + 2;
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic signed [XW-1:0] K = XW'(24'h26DD3B);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_next;
  logic signed [XW-1:0] x, y, z;
  logic signed [XW-1:0] x_next, y_next, z_next, atan_c;
  logic [CW-1:0]        iter;
  logic                 accept_c, last_c;
  logic                 in_ready_q, out_valid_q;
  logic [WIDTH-1:0]     cos_q, sin_q;

  // atan(2^-i) in Q2.22; past i=8 the table collapses to 2^(FRAC-i)
  function automatic logic [XW-1:0] atan_rom(input logic [CW-1:0] idx);
    case (idx)
      CW'(0):  return XW'(24'h3243F7);
      CW'(1):  return XW'(24'h1DAC67);
      CW'(2):  return XW'(24'h0FADBB);
      CW'(3):  return XW'(24'h07F56F);
      CW'(4):  return XW'(24'd261803);
      CW'(5):  return XW'(24'd131029);
      CW'(6):  return XW'(24'd65531);
      CW'(7):  return XW'(24'd32767);
      default: return (idx <= CW'(FRAC)) ? (XW'(1) << (CW'(FRAC) - idx)) : '0;
    endcase
  endfunction

  // One micro-rotation, direction chosen by the sign of the residual angle
  always_comb begin
    accept_c = bus.in_valid && in_ready_q;
    last_c   = (state == RUN) && (iter == CW'(ITERATIONS - 1));
    atan_c   = $signed(atan_rom(iter));
    if (!z[XW-1]) begin
      x_next = x - (y >>> iter);
      y_next = y + (x >>> iter);
      z_next = z - atan_c;
    end else begin
      x_next = x + (y >>> iter);
      y_next = y - (x >>> iter);
      z_next = z + atan_c;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_c)      state_next = RUN;
      RUN:     if (last_c)        state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cos_q       <= '0;
      sin_q       <= '0;
      iter        <= '0;
      x           <= '0;
      y           <= '0;
      z           <= '0;
    end else begin
      in_ready_q  <= (state_next == IDLE);
      out_valid_q <= (state_next == DONE);
      if (accept_c) begin
        x    <= K;
        y    <= '0;
        z    <= {{2{bus.theta[WIDTH-1]}}, bus.theta};
        iter <= '0;
      end else if (state == RUN) begin
        x    <= x_next;
        y    <= y_next;
        z    <= z_next;
        iter <= iter + CW'(1);
      end
      if (last_c) begin
        cos_q <= x_next[WIDTH-1:0];
        sin_q <= y_next[WIDTH-1:0];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cos_out   = cos_q;
  assign bus.sin_out   = sin_q;
endmodule
